// File: rtl/majority_sampler_if.sv
// Bus between the sampler and its neighbours: sampling controls in, voted window out.
interface majority_sampler_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div;
    logic             din;
    logic             clr_cnt;
    logic             a;
    logic             b;
    logic             c;
    logic             r;
    logic             valid;
    logic [ERR_W-1:0] disagree_cnt;

    modport master (
        output en, div, din, clr_cnt,
        input  a, b, c, r, valid, disagree_cnt
    );

    modport slave (
        input  en, div, din, clr_cnt,
        output a, b, c, r, valid, disagree_cnt
    );
endinterface

// File: rtl/majority_sampler.sv
// Triple-samples a synchronised serial input at a programmable spacing and presents
// the three samples, their majority vote and a saturating disagreement count.
module majority_sampler #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    majority_sampler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SA, SB, SC} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_div, last_cnt;
    logic             sync1_q, sync2_q, din_s;
    logic             a_q, a_d, b_q, b_d, c_q, c_d, r_q, r_d;
    logic             valid_q, valid_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             tick, overrun, disagree;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    // Two-flop synchroniser; din_s is the only view of din the sampler uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.din;
            sync2_q <= sync1_q;
        end
    end

    assign din_s = sync2_q;

    always_comb begin
        eff_div  = (bus.div == '0) ? CNT_W'(1) : bus.div;
        last_cnt = eff_div - CNT_W'(1);
        tick     = (state_q != IDLE) && (cnt_q == last_cnt);
        // A shrinking div can leave cnt beyond the new end: restart without a tick.
        overrun  = cnt_q > last_cnt;
        disagree = !((a_q == b_q) && (b_q == din_s));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            r_q     <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (tick || overrun) ? '0 : cnt_q + CNT_W'(1);
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        r_d     = r_q;
        valid_d = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) state_d = SA;
            end
            SA: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    a_d     = din_s;
                    state_d = SB;
                end
            end
            SB: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    b_d     = din_s;
                    state_d = SC;
                end
            end
            SC: begin
                // A window whose last sample lands on this edge completes even if en just fell.
                if (tick) begin
                    c_d     = din_s;
                    r_d     = maj3(a_q, b_q, din_s);
                    valid_d = 1'b1;
                    if (disagree) err_d = sat_inc(err_q);
                    state_d = bus.en ? SA : IDLE;
                    cnt_d   = '0;
                end else if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (bus.clr_cnt) err_d = '0;
    end

    assign bus.a            = a_q;
    assign bus.b            = b_q;
    assign bus.c            = c_q;
    assign bus.r            = r_q;
    assign bus.valid        = valid_q;
    assign bus.disagree_cnt = err_q;

endmodule

// File: tb/tb_majority_sampler.sv
// Directed bench for majority_sampler: expected windows are queued as stimulus is
// driven and compared (content and arrival cycle) whenever valid pulses.
module tb_majority_sampler;

    localparam int CNT_W = 8;
    localparam int ERR_W = 2;

    typedef struct packed {
        logic        a;
        logic        b;
        logic        c;
        logic        r;
        logic [1:0]  cnt;
        int unsigned at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          nvalid = 0;
    int          npushed = 0;
    exp_t        q[$];

    majority_sampler_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    majority_sampler #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic a, input logic b, input logic c, input logic r,
                        input logic [1:0] cnt, input int unsigned at);
        exp_t e;
        e.a = a; e.b = b; e.c = c; e.r = r; e.cnt = cnt; e.at = at;
        q.push_back(e);
        npushed++;
    endtask

    // Scoreboard: every valid pulse must match the oldest queued window.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            nvalid++;
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("window_abcr", {28'd0, bus.a, bus.b, bus.c, bus.r},
                    {28'd0, e.a, e.b, e.c, e.r});
                chk("window_cnt", {30'd0, bus.disagree_cnt}, {30'd0, e.cnt});
                chk("window_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic idle_gap(input int n);
        bus.en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    logic [11:0] pat;
    int unsigned t0;
    int          snap;

    initial begin
        bus.en      = 1'b0;
        bus.div     = 8'd2;
        bus.din     = 1'b1;
        bus.clr_cnt = 1'b0;

        // 1: reset values, then no valid while en stays low
        repeat (3) @(negedge clk);
        chk("rst_abcrv", {27'd0, bus.a, bus.b, bus.c, bus.r, bus.valid}, 32'd0);
        chk("rst_cnt", {30'd0, bus.disagree_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("en_low_no_valid", nvalid, 0);
        chk("en_low_outputs", {27'd0, bus.a, bus.b, bus.c, bus.r, bus.valid}, 32'd0);

        // 2: spacing with din=1, div=2 then div=0
        bus.div = 8'd2;
        bus.en  = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3; i++) push(1, 1, 1, 1, 2'd0, t0 + 7 + 6 * i);
        wait_drain();
        idle_gap(4);
        bus.div = 8'd0;
        bus.en  = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3; i++) push(1, 1, 1, 1, 2'd0, t0 + 4 + 3 * i);
        wait_drain();
        idle_gap(4);

        // 3: glitch caught by b, then by a and c
        bus.div = 8'd4;
        bus.en  = 1'b1;
        t0 = cyc;
        push(1, 0, 1, 1, 2'd1, t0 + 13);
        repeat (6) @(negedge clk);
        bus.din = 1'b0;
        @(negedge clk);
        bus.din = 1'b1;
        wait_drain();
        idle_gap(4);
        bus.en = 1'b1;
        t0 = cyc;
        push(0, 1, 0, 0, 2'd2, t0 + 13);
        repeat (2) @(negedge clk);
        bus.din = 1'b0;
        @(negedge clk);
        bus.din = 1'b1;
        repeat (7) @(negedge clk);
        bus.din = 1'b0;
        @(negedge clk);
        bus.din = 1'b1;
        wait_drain();
        idle_gap(4);

        // 4: abort in SB, then a full window after re-enable
        snap = nvalid;
        bus.en = 1'b1;
        repeat (6) @(negedge clk);
        bus.en = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_valid", nvalid, snap);
        chk("abort_abcr", {28'd0, bus.a, bus.b, bus.c, bus.r}, {28'd0, 4'b1100});
        chk("abort_cnt", {30'd0, bus.disagree_cnt}, 32'd2);
        bus.en = 1'b1;
        t0 = cyc;
        push(1, 1, 1, 1, 2'd2, t0 + 13);
        wait_drain();
        idle_gap(4);

        // 5: clear, saturation over four disagreeing windows, clear on tick
        bus.clr_cnt = 1'b1;
        @(negedge clk);
        bus.clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_idle", {30'd0, bus.disagree_cnt}, 32'd0);
        bus.div = 8'd2;
        pat = 12'b100_011_110_101;
        bus.en = 1'b1;
        t0 = cyc;
        push(1, 0, 1, 1, 2'd1, t0 + 7);
        push(0, 1, 1, 1, 2'd2, t0 + 13);
        push(1, 1, 0, 1, 2'd3, t0 + 19);
        push(0, 0, 1, 0, 2'd3, t0 + 25);
        for (int j = 0; j < 24; j++) begin
            bus.din = pat[j / 2];
            @(negedge clk);
        end
        wait_drain();
        idle_gap(4);
        bus.din = 1'b0;
        bus.en  = 1'b1;
        t0 = cyc;
        push(0, 1, 1, 1, 2'd0, t0 + 7);
        @(negedge clk);
        bus.din = 1'b1;
        repeat (5) @(negedge clk);
        bus.clr_cnt = 1'b1;
        @(negedge clk);
        bus.clr_cnt = 1'b0;
        wait_drain();
        idle_gap(4);

        // 6: asynchronous reset while in SC
        bus.en = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_abcrv", {27'd0, bus.a, bus.b, bus.c, bus.r, bus.valid}, 32'd0);
        chk("async_rst_cnt", {30'd0, bus.disagree_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        push(1, 1, 1, 1, 2'd0, t0 + 7);
        wait_drain();
        idle_gap(8);

        chk("total_valids", nvalid, npushed);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
